sa_feeder_2x2: RTL
==================

# sa_feeder_2x2

Controller that drives the 2x2 systolic array's four edge inputs with correctly skewed operand streams and collects the four accumulated results. It takes two 2x2 operand matrices A and B, clears the array, feeds A row-wise from the west and B column-wise from the north with a one-cycle stagger per row/column, flushes the pipeline, and latches the results. It sits between the host/register interface and the array, and replaces hand-written skewed stimulus.

## Interface
- `DW`, 16, operand element width; also the width of each array edge input
- `AW`, 32, accumulator/result width; matches the array outputs
- `FLUSH`, 3, zero-input cycles after the last operand; legal range 2..15
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state and outputs
- `start` in 1: request one multiply; sampled only in IDLE
- `mat_a` in 4*DW: A elements {a11,a10,a01,a00}; a00 in the LSBs
- `mat_b` in 4*DW: B elements {b11,b10,b01,b00}; b00 in the LSBs
- `sa_out_00`, `sa_out_01`, `sa_out_10`, `sa_out_11` in AW each: array accumulator outputs
- `sa_clr` out 1: array clear; array reset input ORed with system reset at top level
- `sa_in_00_W`, `sa_in_10_W` out DW each: west inputs for rows 0 and 1
- `sa_in_00_N`, `sa_in_01_N` out DW each: north inputs for columns 0 and 1
- `busy` out 1: high from CLEAR through DONE
- `done` out 1: one-cycle pulse when the result registers are valid
- `res_00`, `res_01`, `res_10`, `res_11` out AW each: C = A*B, held until the next DONE

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- FSM states are IDLE -> CLEAR -> FEED -> FLUSH -> DONE -> IDLE.
- **IDLE**
  - Stream outputs are 0.
  - When `start` is 1 at a rising edge, mat_a and mat_b are captured into internal registers and the state moves to CLEAR.
- **CLEAR** (1 cycle)
  - `sa_clr` = 1 and streams are 0.
- **FEED** (3 cycles, k = 0..2). Stream values are {00_W, 00_N, 10_W, 01_N}:
  - k=0: {a00, b00, 0, 0}
  - k=1: {a01, b10, a10, b01}
  - k=2: {0, 0, a11, b11}
- **FLUSH** (FLUSH cycles)
  - All streams are 0.
- **DONE** (1 cycle)
  - `done` = 1.
  - res_xx <= sa_out_xx on the edge that enters DONE, so the results are valid while `done` = 1.
- Arithmetic belongs to the array. The feeder does not truncate or extend; result width is AW, and overflow wraps modulo 2^AW inside the array.
- Boundary conditions:
  - `start` while busy is ignored; no queueing. Operand registers are not changed mid-operation.
  - `start` held high through DONE starts a new operation on the cycle after DONE, because IDLE samples it.
  - mat_a and mat_b changing after capture have no effect.
  - `reset` mid-operation asynchronously returns the block to IDLE with all outputs 0, including res_xx.
  - All-zero operands still run the full sequence and return zero results.

## Timing
Cycle 0 is the edge that samples `start`.
- Cycle 1: CLEAR, `sa_clr` = 1.
- Cycles 2-4: FEED k = 0..2.
- Cycles 5 to 4+FLUSH: FLUSH.
- Cycle 5+FLUSH: DONE. With the default FLUSH=3, `done` is high in cycle 8.
- Total occupancy is 5+FLUSH cycles, so back-to-back throughput is one product per 6+FLUSH cycles.
- FLUSH ≥ 2 is required because a11/b11 reach PE11 one cycle after FEED k=2 and its accumulator is stable one cycle later.

## Structure
- Shared header `sa_defs.vh` holds:
  - DW and AW defaults.
  - State encodings: IDLE=0, CLEAR=1, FEED=2, FLUSH=3, DONE=4 as 3-bit localparams.
  - The FEED length constant (3 = 2N-1 for N=2).
- A sub-module is not warranted. The design is a single module with the FSM, one 4-bit phase counter reused for FEED and FLUSH, the operand registers and the result registers.
- The top level instantiates `sa_feeder_2x2` alongside the array.

## Test plan
- **Reset:** assert reset mid-FEED -> all outputs are 0 immediately and the state is IDLE. After release, `start` runs normally.
- **Basic multiply:** A=[[1,2],[3,4]], B=[[5,6],[7,8]], one `start` pulse ->
  - cycles 2/3/4 show streams {1,5,0,0}, {2,7,3,6}, {0,0,4,8};
  - `done` in cycle 8;
  - res = 19, 22, 43, 50.
- **Busy/start:** pulse `start` again in cycle 4 with different operands -> ignored. Results remain 19/22/43/50 and `busy` stays high through cycle 8.
- **Back-to-back:** `start` held high, second operand set A=I, B=[[9,10],[11,12]] -> second `done` at cycle 8+9=17 with res = 9, 10, 11, 12. `sa_clr` pulses before each FEED.
- **Width/overflow:** A=[[65535,65535],[0,0]], B=[[65535,0],[65535,0]] -> res_00 = 2*65535² mod 2^32 = 0xFFFC0002 (8589672450 mod 2^32), and the other results are 0.
- **FLUSH=2 build:** repeat the basic multiply -> `done` in cycle 7 with identical results.

Source files
------------

// File: rtl/sa_feeder_2x2_pkg.sv
// Shared constants and state encoding for the 2x2 systolic-array feeder.
package sa_feeder_2x2_pkg;

  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 32;
  localparam int FLUSH_DEF = 3;
  // Skewed feed length for an NxN array is 2N-1.
  localparam int FEED_LEN  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sa_feeder_2x2_if.sv
// Host-side request/result signals and array-side edge streams of the feeder.
interface sa_feeder_2x2_if #(
  parameter int DW = 16,
  parameter int AW = 32
);

  logic            start;
  logic [4*DW-1:0] mat_a;
  logic [4*DW-1:0] mat_b;
  logic            busy;
  logic            done;
  logic [AW-1:0]   res_00;
  logic [AW-1:0]   res_01;
  logic [AW-1:0]   res_10;
  logic [AW-1:0]   res_11;

  logic            sa_clr;
  logic [DW-1:0]   sa_in_00_W;
  logic [DW-1:0]   sa_in_10_W;
  logic [DW-1:0]   sa_in_00_N;
  logic [DW-1:0]   sa_in_01_N;
  logic [AW-1:0]   sa_out_00;
  logic [AW-1:0]   sa_out_01;
  logic [AW-1:0]   sa_out_10;
  logic [AW-1:0]   sa_out_11;

  modport slave (
    input  start, mat_a, mat_b, sa_out_00, sa_out_01, sa_out_10, sa_out_11,
    output busy, done, res_00, res_01, res_10, res_11,
    output sa_clr, sa_in_00_W, sa_in_10_W, sa_in_00_N, sa_in_01_N
  );

  modport master (
    output start, mat_a, mat_b, sa_out_00, sa_out_01, sa_out_10, sa_out_11,
    input  busy, done, res_00, res_01, res_10, res_11,
    input  sa_clr, sa_in_00_W, sa_in_10_W, sa_in_00_N, sa_in_01_N
  );

endinterface

// File: rtl/sa_feeder_2x2.sv
// Sequences clear, skewed operand feed, flush and result capture for a 2x2
// systolic array; every output is registered alongside the state.
module sa_feeder_2x2
  import sa_feeder_2x2_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int FLUSH = FLUSH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  sa_feeder_2x2_if.slave bus
);

  localparam logic [DW-1:0] ZERO_DW = {DW{1'b0}};
  localparam logic [AW-1:0] ZERO_AW = {AW{1'b0}};

  state_t          state_r;
  logic [3:0]      phase_r;
  logic [4*DW-1:0] a_r;
  logic [4*DW-1:0] b_r;
  logic            sa_clr_r;
  logic            busy_r;
  logic            done_r;
  logic [DW-1:0]   w0_r, w1_r, n0_r, n1_r;
  logic [AW-1:0]   res00_r, res01_r, res10_r, res11_r;

  logic [DW-1:0]   a00_s, a01_s, a10_s, a11_s;
  logic [DW-1:0]   b00_s, b01_s, b10_s, b11_s;

  assign a00_s = a_r[DW-1:0];
  assign a01_s = a_r[2*DW-1:DW];
  assign a10_s = a_r[3*DW-1:2*DW];
  assign a11_s = a_r[4*DW-1:3*DW];
  assign b00_s = b_r[DW-1:0];
  assign b01_s = b_r[2*DW-1:DW];
  assign b10_s = b_r[3*DW-1:2*DW];
  assign b11_s = b_r[4*DW-1:3*DW];

  // Sequencer: outputs are loaded for the state being entered so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      phase_r  <= 4'd0;
      a_r      <= {(4*DW){1'b0}};
      b_r      <= {(4*DW){1'b0}};
      sa_clr_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      w0_r     <= ZERO_DW;
      w1_r     <= ZERO_DW;
      n0_r     <= ZERO_DW;
      n1_r     <= ZERO_DW;
      res00_r  <= ZERO_AW;
      res01_r  <= ZERO_AW;
      res10_r  <= ZERO_AW;
      res11_r  <= ZERO_AW;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r      <= bus.mat_a;
            b_r      <= bus.mat_b;
            sa_clr_r <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= ST_CLEAR;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          sa_clr_r <= 1'b0;
          w0_r     <= a00_s;
          n0_r     <= b00_s;
          w1_r     <= ZERO_DW;
          n1_r     <= ZERO_DW;
          phase_r  <= 4'd0;
          state_r  <= ST_FEED;
        end
        ST_FEED: begin
          // Row 1 / column 1 trail row 0 / column 0 by one cycle.
          if (phase_r == 4'(FEED_LEN - 1)) begin
            w0_r    <= ZERO_DW;
            n0_r    <= ZERO_DW;
            w1_r    <= ZERO_DW;
            n1_r    <= ZERO_DW;
            phase_r <= 4'd0;
            state_r <= ST_FLUSH;
          end else if (phase_r == 4'd0) begin
            w0_r    <= a01_s;
            n0_r    <= b10_s;
            w1_r    <= a10_s;
            n1_r    <= b01_s;
            phase_r <= phase_r + 4'd1;
          end else begin
            w0_r    <= ZERO_DW;
            n0_r    <= ZERO_DW;
            w1_r    <= a11_s;
            n1_r    <= b11_s;
            phase_r <= phase_r + 4'd1;
          end
        end
        ST_FLUSH: begin
          if (phase_r == 4'(FLUSH - 1)) begin
            phase_r <= 4'd0;
            done_r  <= 1'b1;
            res00_r <= bus.sa_out_00;
            res01_r <= bus.sa_out_01;
            res10_r <= bus.sa_out_10;
            res11_r <= bus.sa_out_11;
            state_r <= ST_DONE;
          end else begin
            phase_r <= phase_r + 4'd1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          sa_clr_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
          w0_r     <= ZERO_DW;
          w1_r     <= ZERO_DW;
          n0_r     <= ZERO_DW;
          n1_r     <= ZERO_DW;
          phase_r  <= 4'd0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sa_clr     = sa_clr_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.sa_in_00_W = w0_r;
  assign bus.sa_in_10_W = w1_r;
  assign bus.sa_in_00_N = n0_r;
  assign bus.sa_in_01_N = n1_r;
  assign bus.res_00     = res00_r;
  assign bus.res_01     = res01_r;
  assign bus.res_10     = res10_r;
  assign bus.res_11     = res11_r;

endmodule
